divider_seq: RTL

//   Iterative restoring divider: unsigned DW-bit dividend / VW-bit divisor -> DW-bit quotient + VW-bit remainder.
//   One quotient bit per clock. Inverse of the 8x8 multiply path: takes a 16-bit product-width operand back down.

---
 rtl/div_pkg.sv | 18 +
 rtl/divider_step.sv | 28 ++
 rtl/divider_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider (divider_seq).
package div_pkg;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width: must hold the value DW.
  function automatic int cnt_width(input int dw);
    return $clog2(dw) + 1;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// conditionally subtract the divisor from the partial remainder.
module divider_step
  import div_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW:0]   r,
  input  logic          nbit,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   r_next,
  output logic          qbit
);

  logic [VW:0]   shifted;
  logic [VW+1:0] diff;

  // Trial subtraction; the extra MSB of diff is the borrow.
  // r[VW] can only be set when the divisor is 0, where the trial always
  // succeeds anyway, so OR-ing it into qbit leaves the result unchanged.
  always_comb begin
    shifted = {r[VW-1:0], nbit};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    qbit    = ~diff[VW+1] | r[VW];
    r_next  = qbit ? diff[VW:0] : shifted;
  end

endmodule

// File: rtl/divider_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock,
// valid/ready handshake on both sides.
// Optional feature macro: DIV_ZERO_FLAG_EN (adds div_by_zero output and a
// one-cycle fast path for a zero divisor).
module divider_seq
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
`ifdef DIV_ZERO_FLAG_EN
  output logic          div_by_zero,
`endif
  output logic [VW-1:0] remainder
);

  localparam int CW = cnt_width(DW);

  state_t        state, state_nx;
  logic [CW-1:0] count;
  // Holds the dividend at acceptance; quotient bits enter at the LSB as
  // dividend bits leave at the MSB, so it ends up holding the quotient.
  logic [DW-1:0] dq_sh;
  logic [VW-1:0] dvs;
  logic [VW:0]   r;
  logic [VW:0]   r_nx;
  logic          qbit;
  logic          accept;
  logic          last;
`ifdef DIV_ZERO_FLAG_EN
  logic          zdet;
`endif

  assign accept = in_valid && in_ready;
  assign last   = (state == BUSY) && (count == CW'(1));

  divider_step #(.VW(VW)) u_step (
    .r       (r),
    .nbit    (dq_sh[DW-1]),
    .divisor (dvs),
    .r_next  (r_nx),
    .qbit    (qbit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        if (count == CW'(1)) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      dq_sh     <= '0;
      dvs       <= '0;
      r         <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_FLAG_EN
      zdet        <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else if (accept) begin
      dq_sh <= dividend;
      dvs   <= divisor;
      r     <= '0;
      count <= CW'(DW);
`ifdef DIV_ZERO_FLAG_EN
      // Zero divisor: run a single BUSY cycle that only loads the fixed result.
      zdet <= (divisor == '0);
      if (divisor == '0) count <= CW'(1);
`endif
    end else if (state == BUSY) begin
      dq_sh <= {dq_sh[DW-2:0], qbit};
      r     <= r_nx;
      count <= count - CW'(1);
      if (last) begin
        quotient  <= {dq_sh[DW-2:0], qbit};
        remainder <= r_nx[VW-1:0];
`ifdef DIV_ZERO_FLAG_EN
        if (zdet) begin
          quotient    <= '1;
          remainder   <= dq_sh[VW-1:0];
          div_by_zero <= 1'b1;
        end
`endif
      end
    end else if (out_valid && out_ready) begin
`ifdef DIV_ZERO_FLAG_EN
      div_by_zero <= 1'b0;
`endif
    end
  end

endmodule
